add4_share_arb: RTL and testbench

- Round-robin arbiter and sequencer that shares one sync_adder4 instance among NREQ requesters.
- Accepts operand triples (x, y, cin) over valid/ready and drives the adder's registered inputs.
- Tracks in-flight operations through the adder latency and returns each result tagged with its requester ID through a credit-protected response FIFO.
- Sits between pipeline front-end requesters and the shared 4-bit adder datapath.

---
 rtl/add4_share_arb.sv | 166 ++++++++++++++++
 tb/tb_add4_share_arb.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/add4_share_arb.sv
// Round-robin arbiter that shares one external sync_adder4 among NREQ requesters.
// Define ADD4_ARB_FIXED_PRI_EN to replace round-robin with lowest-index-wins priority.
module add4_share_arb #(
    parameter int NREQ      = 4,
    parameter int IDW       = 2,
    parameter int ADD_LAT   = 1,
    parameter int RSP_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [4*NREQ-1:0] req_x,
    input  logic [4*NREQ-1:0] req_y,
    input  logic [NREQ-1:0]   req_cin,
    output logic [3:0]        add_x,
    output logic [3:0]        add_y,
    output logic              add_cin,
    input  logic [3:0]        add_s,
    input  logic              add_cout,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [3:0]        rsp_s,
    output logic              rsp_cout,
    output logic              busy
);

    localparam int PW  = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int CW  = $clog2(RSP_DEPTH + 1);
    localparam int IFW = $clog2(ADD_LAT + 2);
    localparam int EW  = IDW + 5;
    localparam logic [31:0] DEPTH_U = RSP_DEPTH;

    logic [IDW-1:0] tag_id    [ADD_LAT+1];
    logic           tag_valid [ADD_LAT+1];
    logic [IFW-1:0] inflight;
    logic [CW-1:0]  fifo_count;
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic [EW-1:0]  mem [RSP_DEPTH];
    logic [EW-1:0]  head;

    logic           can_issue;
    logic           found;
    logic           issue;
    logic           push;
    logic           pop;
    logic [IDW-1:0] grant_id;
    logic [3:0]     sel_x;
    logic [3:0]     sel_y;
    logic           sel_cin;
    int             idx;

`ifndef ADD4_ARB_FIXED_PRI_EN
    logic [IDW-1:0] last;
`endif

    // Credits come only from registered counts, so a pop frees a slot one cycle later.
    assign can_issue = (32'(fifo_count) + 32'(inflight)) < DEPTH_U;

    always_comb begin
        found    = 1'b0;
        grant_id = '0;
        sel_x    = '0;
        sel_y    = '0;
        sel_cin  = 1'b0;
        idx      = 0;
`ifdef ADD4_ARB_FIXED_PRI_EN
        for (int i = 0; i < NREQ; i++) begin
            if (!found && req_valid[i]) begin
                found    = 1'b1;
                grant_id = IDW'(i);
                sel_x    = req_x[4*i +: 4];
                sel_y    = req_y[4*i +: 4];
                sel_cin  = req_cin[i];
            end
        end
`else
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(last) + k) % NREQ;
            if (!found && req_valid[idx]) begin
                found    = 1'b1;
                grant_id = IDW'(idx);
                sel_x    = req_x[4*idx +: 4];
                sel_y    = req_y[4*idx +: 4];
                sel_cin  = req_cin[idx];
            end
        end
`endif
    end

    assign issue     = found & can_issue;
    assign req_ready = (issue & rst_b) ? (NREQ'(1) << grant_id) : '0;
    assign push      = tag_valid[ADD_LAT];
    assign rsp_valid = (fifo_count != '0);
    assign pop       = rsp_valid & rsp_ready;
    assign busy      = (inflight != '0) | (fifo_count != '0);

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            add_x    <= '0;
            add_y    <= '0;
            add_cin  <= 1'b0;
            inflight <= '0;
            for (int i = 0; i <= ADD_LAT; i++) begin
                tag_valid[i] <= 1'b0;
                tag_id[i]    <= '0;
            end
        end else begin
            if (issue) begin
                add_x   <= sel_x;
                add_y   <= sel_y;
                add_cin <= sel_cin;
            end
            tag_valid[0] <= issue;
            tag_id[0]    <= grant_id;
            for (int i = 1; i <= ADD_LAT; i++) begin
                tag_valid[i] <= tag_valid[i-1];
                tag_id[i]    <= tag_id[i-1];
            end
            case ({issue, push})
                2'b10:   inflight <= inflight + 1'b1;
                2'b01:   inflight <= inflight - 1'b1;
                default: inflight <= inflight;
            endcase
        end
    end

`ifndef ADD4_ARB_FIXED_PRI_EN
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            last <= IDW'(NREQ - 1);
        end else if (issue) begin
            last <= grant_id;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            fifo_count <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Storage needs no reset: the head is masked whenever the count is zero.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {tag_id[ADD_LAT], add_s, add_cout};
    end

    assign head     = mem[rd_ptr];
    assign rsp_id   = rsp_valid ? head[EW-1:5] : '0;
    assign rsp_s    = rsp_valid ? head[4:1]    : '0;
    assign rsp_cout = rsp_valid ? head[0]      : 1'b0;

endmodule

// File: tb/tb_add4_share_arb.sv
// Self-checking bench for add4_share_arb with a behavioural sync_adder4 and a response scoreboard.
// Covers ADD4_ARB_FIXED_PRI_EN when the bench and RTL are built with that macro.
module tb_add4_share_arb;

    localparam int NREQ      = 4;
    localparam int IDW       = 2;
    localparam int ADD_LAT   = 1;
    localparam int RSP_DEPTH = 4;

    logic              clk = 1'b0;
    logic              rst_b;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [4*NREQ-1:0] req_x;
    logic [4*NREQ-1:0] req_y;
    logic [NREQ-1:0]   req_cin;
    logic [3:0]        add_x;
    logic [3:0]        add_y;
    logic              add_cin;
    logic [3:0]        add_s;
    logic              add_cout;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [3:0]        rsp_s;
    logic              rsp_cout;
    logic              busy;

    add4_share_arb #(.NREQ(NREQ), .IDW(IDW), .ADD_LAT(ADD_LAT), .RSP_DEPTH(RSP_DEPTH)) dut (
        .clk(clk), .rst_b(rst_b),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_x(req_x), .req_y(req_y), .req_cin(req_cin),
        .add_x(add_x), .add_y(add_y), .add_cin(add_cin),
        .add_s(add_s), .add_cout(add_cout),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_s(rsp_s), .rsp_cout(rsp_cout),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Behavioural sync_adder4: result appears ADD_LAT clocks after its inputs change.
    logic [4:0] sum_pipe [ADD_LAT];
    always @(posedge clk) begin
        sum_pipe[0] <= {1'b0, add_x} + {1'b0, add_y} + {4'b0, add_cin};
        for (int i = 1; i < ADD_LAT; i++) sum_pipe[i] <= sum_pipe[i-1];
    end
    assign add_s    = sum_pipe[ADD_LAT-1][3:0];
    assign add_cout = sum_pipe[ADD_LAT-1][4];

    typedef struct {
        bit         v;
        int         id;
        logic [3:0] s;
        logic       c;
    } tag_t;

    tag_t       m_pipe [ADD_LAT+1];
    tag_t       exp_q  [$];
    int         m_last;
    int         eg;
    bit         pop_now;
    logic [3:0] opx [NREQ];
    logic [3:0] opy [NREQ];
    logic       opc [NREQ];
    bit         oneshot [NREQ];
    int         checks = 0;
    int         errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i <= ADD_LAT; i++) m_pipe[i] = '{v: 1'b0, id: 0, s: 4'h0, c: 1'b0};
        exp_q.delete();
        m_last = NREQ - 1;
    endtask

    task automatic applyStimulus(input int i, input logic [3:0] x, input logic [3:0] y,
                                 input logic c, input bit once);
        opx[i] = x;
        opy[i] = y;
        opc[i] = c;
        oneshot[i] = once;
        req_x[4*i +: 4] = x;
        req_y[4*i +: 4] = y;
        req_cin[i] = c;
        req_valid[i] = 1'b1;
    endtask

    // Predicts the grant from the credit rule and compares every output against the scoreboard head.
    task automatic checkOutput();
        int infl;
        logic [NREQ-1:0] exp_ready;
        infl = 0;
        for (int i = 0; i <= ADD_LAT; i++) if (m_pipe[i].v) infl++;
        eg = -1;
        if (exp_q.size() + infl < RSP_DEPTH) begin
`ifdef ADD4_ARB_FIXED_PRI_EN
            for (int j = 0; j < NREQ; j++) if (eg < 0 && req_valid[j]) eg = j;
`else
            for (int k = 1; k <= NREQ; k++) begin
                int j;
                j = (m_last + k) % NREQ;
                if (eg < 0 && req_valid[j]) eg = j;
            end
`endif
        end
        exp_ready = (eg >= 0) ? NREQ'(1) << eg : '0;
        chk("req_ready", 32'(req_ready), 32'(exp_ready));
        chk("busy", 32'(busy), 32'((infl != 0) || (exp_q.size() != 0)));
        if (exp_q.size() != 0) begin
            chk("rsp_valid", 32'(rsp_valid), 32'd1);
            chk("rsp_id", 32'(rsp_id), 32'(exp_q[0].id));
            chk("rsp_s", 32'(rsp_s), 32'(exp_q[0].s));
            chk("rsp_cout", 32'(rsp_cout), 32'(exp_q[0].c));
        end else begin
            chk("rsp_valid_idle", 32'(rsp_valid), 32'd0);
            chk("rsp_fields_idle", {27'd0, rsp_id, rsp_s, rsp_cout}, 32'd0);
        end
        pop_now = (exp_q.size() != 0) && (rsp_ready === 1'b1);
    endtask

    task automatic tick();
        logic [4:0] sum;
        @(negedge clk);
        checkOutput();
        @(posedge clk);
        #1;
        if (pop_now) void'(exp_q.pop_front());
        if (m_pipe[ADD_LAT].v) exp_q.push_back(m_pipe[ADD_LAT]);
        for (int i = ADD_LAT; i > 0; i--) m_pipe[i] = m_pipe[i-1];
        if (eg >= 0) begin
            sum = {1'b0, opx[eg]} + {1'b0, opy[eg]} + {4'b0, opc[eg]};
            m_pipe[0] = '{v: 1'b1, id: eg, s: sum[3:0], c: sum[4]};
            m_last = eg;
            if (oneshot[eg]) req_valid[eg] = 1'b0;
        end else begin
            m_pipe[0].v = 1'b0;
        end
        if (exp_q.size() > RSP_DEPTH) chk("fifo_overflow", 32'(exp_q.size()), 32'(RSP_DEPTH));
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        rst_b     = 1'b0;
        req_valid = '0;
        req_x     = '0;
        req_y     = '0;
        req_cin   = '0;
        rsp_ready = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            opx[i] = 4'h0; opy[i] = 4'h0; opc[i] = 1'b0; oneshot[i] = 1'b0;
        end
        modelReset();
        @(posedge clk);
        #1;
        chk("reset_ready", 32'(req_ready), 32'd0);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_add", {23'd0, add_x, add_y, add_cin}, 32'd0);
        @(posedge clk);
        #1;
        rst_b = 1'b1;
        ticks(2);

        $display("[TB] single op");
        applyStimulus(0, 4'd4, 4'd9, 1'b1, 1'b1);
        ticks(3);
        chk("single_valid", 32'(rsp_valid), 32'd1);
        chk("single_id", 32'(rsp_id), 32'd0);
        chk("single_s", 32'(rsp_s), 32'd14);
        chk("single_cout", 32'(rsp_cout), 32'd0);
        ticks(2);

        $display("[TB] carry");
        applyStimulus(2, 4'd7, 4'd12, 1'b1, 1'b1);
        ticks(3);
        chk("carry_id", 32'(rsp_id), 32'd2);
        chk("carry_s", 32'(rsp_s), 32'd4);
        chk("carry_cout", 32'(rsp_cout), 32'd1);
        ticks(2);

        $display("[TB] fairness");
        applyStimulus(0, 4'd1, 4'd2, 1'b0, 1'b0);
        applyStimulus(1, 4'd15, 4'd15, 1'b1, 1'b0);
        applyStimulus(2, 4'd8, 4'd8, 1'b0, 1'b0);
        applyStimulus(3, 4'd5, 4'd10, 1'b1, 1'b0);
        ticks(12);
        req_valid = '0;
        ticks(4);

        $display("[TB] backpressure");
        rsp_ready = 1'b0;
        req_valid = '1;
        ticks(8);
        chk("bp_ready", 32'(req_ready), 32'd0);
        chk("bp_valid", 32'(rsp_valid), 32'd1);
        chk("bp_busy", 32'(busy), 32'd1);
        rsp_ready = 1'b1;
        ticks(8);
        req_valid = '0;
        ticks(6);

        $display("[TB] reset mid-flight");
        rsp_ready = 1'b0;
        req_valid = '1;
        ticks(3);
        #2;
        rst_b = 1'b0;
        #1;
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);
        req_valid = '0;
        rsp_ready = 1'b1;
        modelReset();
        @(posedge clk);
        #1;
        rst_b = 1'b1;
        ticks(5);
        applyStimulus(3, 4'd9, 4'd9, 1'b0, 1'b1);
        ticks(5);

`ifdef ADD4_ARB_FIXED_PRI_EN
        $display("[TB] fixed priority");
        applyStimulus(1, 4'd3, 4'd3, 1'b0, 1'b0);
        applyStimulus(3, 4'd6, 4'd1, 1'b1, 1'b0);
        ticks(4);
        chk("fixed_grant", 32'(req_ready), 32'd2);
        ticks(4);
        req_valid = '0;
        ticks(5);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
